// File: rtl/slave_rx_port_if.sv
// slave_rx_port_if: serial request/handshake bundle between a bus master and the slave receive port
interface slave_rx_port_if #(
    parameter int BURST_WIDTH = 12
);
    logic master_valid;
    logic slave_ready;
    logic read_en;
    logic write_en;
    logic rx_addr;
    logic rx_data;
    logic [BURST_WIDTH-1:0] burst_len;
    modport master (
        output master_valid, read_en, write_en, rx_addr, rx_data, burst_len,
        input  slave_ready
    );
    modport slave (
        input  master_valid, read_en, write_en, rx_addr, rx_data, burst_len,
        output slave_ready
    );
endinterface

// File: rtl/slave_rx_port.sv
// slave_rx_port: deserialises LSB-first address/data and runs single or incrementing-burst beats toward slave memory
module slave_rx_port #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int BURST_WIDTH = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    slave_rx_port_if.slave         bus,
    output logic [ADDR_WIDTH-1:0]  addr_out,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   wr_valid,
    output logic                   rd_req,
    output logic [BURST_WIDTH:0]   beat_count,
    output logic                   rx_done,
    output logic                   abort
);
    localparam int MW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW = $clog2(MW + 1);
    localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] M_LAST = CW'(MW - 1);

    typedef enum logic [1:0] {IDLE, ADDR, WBURST, RBURST} state_t;

    state_t                 state, state_n;
    logic                   is_wr, is_wr_n;
    logic [BURST_WIDTH-1:0] blen, blen_n;
    logic [CW-1:0]          bit_cnt, bit_cnt_n;
    logic [ADDR_WIDTH-1:0]  addr_sr, addr_sr_n, addr_out_n;
    logic [DATA_WIDTH-1:0]  data_sr, data_sr_n, data_out_n;
    logic [BURST_WIDTH:0]   beat_n, beat_inc, total;
    logic                   ready, ready_n, wr_valid_n, rd_req_n, rx_done_n, abort_n;

    assign bus.slave_ready = ready;
    assign beat_inc = beat_count + 1'b1;
    assign total    = {1'b0, blen} + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            is_wr      <= 1'b0;
            blen       <= '0;
            bit_cnt    <= '0;
            addr_sr    <= '0;
            data_sr    <= '0;
            addr_out   <= '0;
            data_out   <= '0;
            beat_count <= '0;
            ready      <= 1'b0;
            wr_valid   <= 1'b0;
            rd_req     <= 1'b0;
            rx_done    <= 1'b0;
            abort      <= 1'b0;
        end else begin
            state      <= state_n;
            is_wr      <= is_wr_n;
            blen       <= blen_n;
            bit_cnt    <= bit_cnt_n;
            addr_sr    <= addr_sr_n;
            data_sr    <= data_sr_n;
            addr_out   <= addr_out_n;
            data_out   <= data_out_n;
            beat_count <= beat_n;
            ready      <= ready_n;
            wr_valid   <= wr_valid_n;
            rd_req     <= rd_req_n;
            rx_done    <= rx_done_n;
            abort      <= abort_n;
        end
    end

    always_comb begin
        state_n    = state;
        is_wr_n    = is_wr;
        blen_n     = blen;
        bit_cnt_n  = bit_cnt;
        addr_sr_n  = addr_sr;
        data_sr_n  = data_sr;
        addr_out_n = addr_out;
        data_out_n = data_out;
        beat_n     = beat_count;
        ready_n    = ready;
        wr_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        rx_done_n  = 1'b0;
        abort_n    = 1'b0;
        if (state == IDLE) begin
            ready_n = 1'b1;
            if (ready && bus.master_valid && (bus.write_en || bus.read_en)) begin
                is_wr_n   = bus.write_en;
                blen_n    = bus.burst_len;
                beat_n    = '0;
                bit_cnt_n = '0;
                ready_n   = 1'b0;
                state_n   = ADDR;
            end
        end else if (!bus.master_valid) begin
            // abort wins over any beat completing on this edge; partial words are dropped
            abort_n = 1'b1;
            ready_n = 1'b1;
            state_n = IDLE;
        end else begin
            case (state)
                ADDR: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt <= A_LAST) addr_sr_n = ADDR_WIDTH'({bus.rx_addr, addr_sr} >> 1);
                    if (bit_cnt <= D_LAST) data_sr_n = DATA_WIDTH'({bus.rx_data, data_sr} >> 1);
                    if (bit_cnt == (is_wr ? M_LAST : A_LAST)) begin
                        bit_cnt_n  = '0;
                        addr_out_n = addr_sr_n;
                        data_out_n = is_wr ? data_sr_n : data_out;
                        beat_n     = (BURST_WIDTH+1)'(1);
                        wr_valid_n = is_wr;
                        rd_req_n   = !is_wr;
                        if (blen == '0) begin
                            rx_done_n = 1'b1;
                            ready_n   = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            state_n = is_wr ? WBURST : RBURST;
                        end
                    end
                end
                WBURST: begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    data_sr_n = DATA_WIDTH'({bus.rx_data, data_sr} >> 1);
                    if (bit_cnt == D_LAST) begin
                        bit_cnt_n  = '0;
                        addr_out_n = addr_out + 1'b1;
                        data_out_n = data_sr_n;
                        wr_valid_n = 1'b1;
                        beat_n     = beat_inc;
                        if (beat_inc == total) begin
                            rx_done_n = 1'b1;
                            ready_n   = 1'b1;
                            state_n   = IDLE;
                        end
                    end
                end
                RBURST: begin
                    addr_out_n = addr_out + 1'b1;
                    rd_req_n   = 1'b1;
                    beat_n     = beat_inc;
                    if (beat_inc == total) begin
                        rx_done_n = 1'b1;
                        ready_n   = 1'b1;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_slave_rx_port.sv
// tb_slave_rx_port: scoreboard bench for slave_rx_port; expected beats are queued with their due cycle
module tb_slave_rx_port;
    typedef struct {
        int          cyc;
        logic [3:0]  flg;
        logic [11:0] addr;
        logic [15:0] data;
        logic [12:0] beats;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  q1[$];
    ev_t  q2[$];
    ev_t  ev1, ev2;
    logic [7:0]  words [0:7];
    logic [11:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [12:0] m_beats = '0;

    logic [11:0] addr_out;
    logic [7:0]  data_out;
    logic        wr_valid, rd_req, rx_done, abort;
    logic [12:0] beat_count;
    logic [3:0]  addr_out2;
    logic [15:0] data_out2;
    logic        wr_valid2, rd_req2, rx_done2, abort2;
    logic [12:0] beat_count2;

    slave_rx_port_if #(.BURST_WIDTH(12)) bus ();
    slave_rx_port_if #(.BURST_WIDTH(12)) bus2 ();

    slave_rx_port u_dut (
        .clk(clk), .reset(reset), .bus(bus),
        .addr_out(addr_out), .data_out(data_out), .wr_valid(wr_valid), .rd_req(rd_req),
        .beat_count(beat_count), .rx_done(rx_done), .abort(abort)
    );

    slave_rx_port #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BURST_WIDTH(12)) u_dut16 (
        .clk(clk), .reset(reset), .bus(bus2),
        .addr_out(addr_out2), .data_out(data_out2), .wr_valid(wr_valid2), .rd_req(rd_req2),
        .beat_count(beat_count2), .rx_done(rx_done2), .abort(abort2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wr_valid | rd_req | rx_done | abort) begin
            if (q1.size() == 0) begin
                check("unexpected_pulse", {28'd0, wr_valid, rd_req, rx_done, abort}, 32'd0);
            end else begin
                ev1 = q1.pop_front();
                check("evt_cycle", cyc, ev1.cyc);
                check("evt_flags", {28'd0, wr_valid, rd_req, rx_done, abort}, {28'd0, ev1.flg});
                check("evt_addr", {20'd0, addr_out}, {20'd0, ev1.addr});
                check("evt_data", {24'd0, data_out}, {16'd0, ev1.data});
                check("evt_beats", {19'd0, beat_count}, {19'd0, ev1.beats});
            end
        end
    end

    always @(negedge clk) begin
        if (wr_valid2 | rd_req2 | rx_done2 | abort2) begin
            if (q2.size() == 0) begin
                check("unexpected_pulse16", {28'd0, wr_valid2, rd_req2, rx_done2, abort2}, 32'd0);
            end else begin
                ev2 = q2.pop_front();
                check("evt16_cycle", cyc, ev2.cyc);
                check("evt16_flags", {28'd0, wr_valid2, rd_req2, rx_done2, abort2}, {28'd0, ev2.flg});
                check("evt16_addr", {28'd0, addr_out2}, {20'd0, ev2.addr});
                check("evt16_data", {16'd0, data_out2}, {16'd0, ev2.data});
                check("evt16_beats", {19'd0, beat_count2}, {19'd0, ev2.beats});
            end
        end
    end

    // ab: ADDR-relative edge at which master_valid is first seen low (0 = never)
    task automatic run_txn(input logic wr, input logic [11:0] a, input int blen, input int ab);
        int h, last, e;
        logic [11:0] sa;
        logic [7:0]  sd;
        last = wr ? 12 + 8 * blen : 12 + blen;
        @(negedge clk);
        h = cyc + 1;
        m_beats = '0;
        for (int b = 0; b <= blen; b++) begin
            e = wr ? 12 + 8 * b : 12 + b;
            if (ab != 0 && e >= ab) break;
            m_addr  = a + 12'(b);
            m_data  = wr ? words[b] : m_data;
            m_beats = 13'(b + 1);
            q1.push_back('{h + e, {wr, !wr, b == blen, 1'b0}, m_addr, {8'd0, m_data}, m_beats});
        end
        if (ab != 0 && ab <= last)
            q1.push_back('{h + ab, 4'b0001, m_addr, {8'd0, m_data}, m_beats});
        bus.master_valid = 1'b1;
        bus.write_en = wr;
        bus.read_en = !wr;
        bus.burst_len = 12'(blen);
        sa = a;
        sd = '0;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (k == 2) check("rdy_busy", {31'd0, bus.slave_ready}, 32'd0);
            bus.write_en = 1'b0;
            bus.read_en = 1'b0;
            bus.burst_len = 12'($urandom);
            bus.rx_addr = (k <= 12) ? sa[0] : 1'($urandom);
            sa = sa >> 1;
            if (k == 1) sd = words[0];
            else if (k > 12 && (k - 13) % 8 == 0) sd = words[(k - 13) / 8 + 1];
            bus.rx_data = wr ? sd[0] : 1'($urandom);
            sd = sd >> 1;
            bus.master_valid = !(ab != 0 && k >= ab);
            if (ab != 0 && k == ab) break;
        end
        @(negedge clk);
        bus.master_valid = 1'b0;
        bus.rx_addr = 1'b0;
        bus.rx_data = 1'b0;
        check("rdy_after", {31'd0, bus.slave_ready}, 32'd1);
        for (int i = 0; i < 4 && q1.size() != 0; i++) @(negedge clk);
        check("sb_drain", q1.size(), 32'd0);
    endtask

    initial begin
        int h;
        logic [3:0]  sa4;
        logic [15:0] sd16;
        {bus.master_valid, bus.read_en, bus.write_en, bus.rx_addr, bus.rx_data} = '0;
        {bus2.master_valid, bus2.read_en, bus2.write_en, bus2.rx_addr, bus2.rx_data} = '0;
        bus.burst_len = '0;
        bus2.burst_len = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", {addr_out, data_out, beat_count, wr_valid, rd_req, rx_done, abort}, 32'd0);
        check("rst_ready", {31'd0, bus.slave_ready}, 32'd0);
        reset = 1'b0;
        check("rdy_before_edge", {31'd0, bus.slave_ready}, 32'd0);
        @(negedge clk);
        check("rdy_after_reset", {31'd0, bus.slave_ready}, 32'd1);
        check("rdy16_after_reset", {31'd0, bus2.slave_ready}, 32'd1);

        words[0] = 8'hC3;
        run_txn(1'b1, 12'h2A5, 0, 0);
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        run_txn(1'b1, 12'h0FE, 2, 0);
        run_txn(1'b0, 12'hFFE, 3, 0);
        words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3; words[3] = 8'hD4; words[4] = 8'hE5;
        run_txn(1'b1, 12'h7F0, 4, 24);
        run_txn(1'b0, 12'h123, 2, 5);
        words[0] = 8'h5A; words[1] = 8'h96;
        run_txn(1'b1, 12'hFFF, 1, 0);

        @(negedge clk);
        bus.master_valid = 1'b1;
        bus.write_en = 1'b1;
        bus.burst_len = 12'd0;
        repeat (5) @(negedge clk);
        bus.write_en = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_outputs", {addr_out, data_out, beat_count, wr_valid, rd_req, rx_done, abort}, 32'd0);
        check("midrst_ready", {31'd0, bus.slave_ready}, 32'd0);
        m_addr = '0;
        m_data = '0;
        bus.master_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_after_midrst", {31'd0, bus.slave_ready}, 32'd1);
        bus.master_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_handshake", {31'd0, bus.slave_ready}, 32'd1);
        end
        bus.master_valid = 1'b0;
        words[0] = 8'h3C;
        run_txn(1'b1, 12'h801, 0, 0);

        @(negedge clk);
        h = cyc + 1;
        q2.push_back('{h + 16, 4'b1010, 12'h009, 16'hBEEF, 13'd1});
        bus2.master_valid = 1'b1;
        bus2.write_en = 1'b1;
        sa4 = 4'h9;
        sd16 = 16'hBEEF;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus2.write_en = 1'b0;
            bus2.rx_addr = (k <= 4) ? sa4[0] : 1'($urandom);
            sa4 = sa4 >> 1;
            bus2.rx_data = sd16[0];
            sd16 = sd16 >> 1;
        end
        @(negedge clk);
        bus2.master_valid = 1'b0;
        check("rdy16_after", {31'd0, bus2.slave_ready}, 32'd1);
        for (int i = 0; i < 4 && q2.size() != 0; i++) @(negedge clk);
        check("sb16_drain", q2.size(), 32'd0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/slave_rx_port.md
Name: slave_rx_port

Overview:
Parametrised serial slave receive port for the system bus. After a master_valid/slave_ready handshake it deserialises an LSB-first address and, for writes, LSB-first data words. It then executes single or incrementing-burst transfers, emitting per-beat write strobes or read requests toward the slave memory. It adds generic widths, explicit burst length, read-burst request generation, address wrap and abort-on-valid-drop.

Parameters:
DATA_WIDTH, 8, bits per serial data word (>=1)
ADDR_WIDTH, 12, bits per serial address (>=1)
BURST_WIDTH, 12, width of burst_len; beats per transaction = burst_len+1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rx_addr  in  1  serial address bit, LSB first
rx_data  in  1  serial write-data bit, LSB first
master_valid  in  1  master requests/holds transaction; must stay high until rx_done
read_en  in  1  transaction is a read (sampled at handshake)
write_en  in  1  transaction is a write (sampled at handshake; wins over read_en)
burst_len  in  BURST_WIDTH  extra beats after first (sampled at handshake)
slave_ready  out  1  high only in IDLE; handshake = master_valid & slave_ready
addr_out  out  ADDR_WIDTH  current beat address
data_out  out  DATA_WIDTH  last completed write word
wr_valid  out  1  1-cycle pulse: data_out/addr_out hold a complete write beat
rd_req  out  1  1-cycle pulse: read requested at addr_out
beat_count  out  BURST_WIDTH+1  beats completed in current/last transaction
rx_done  out  1  1-cycle pulse: all beats completed
abort  out  1  1-cycle pulse: transaction terminated by master_valid low

Behaviour:
- Reset (async): state=IDLE; all outputs 0, including slave_ready; bit counter cleared. slave_ready rises on the first clk edge after reset deasserts. Reset mid-transfer discards everything; no rx_done or abort is emitted.
- States: IDLE, ADDR (address plus first write word), WBURST (further write words), RBURST (read requests).
- IDLE: slave_ready=1. Handshake edge requires master_valid=1 and (write_en|read_en)=1; otherwise the slave stays in IDLE. On the handshake edge: latch mode (write if write_en, else read) and burst_len; clear beat_count and bit counter; slave_ready<=0; next state ADDR.
- ADDR: bits are sampled on consecutive edges starting with the edge after handshake. Address bit i is taken on edge i+1; write-data bit j is taken on edge j+1 in parallel.
  - Duration is ADDR_WIDTH edges for a read and max(ADDR_WIDTH, DATA_WIDTH) edges for a write.
  - On the last ADDR edge of a write: wr_valid<=1, beat_count<=1, data_out and addr_out updated.
  - On the last ADDR edge of a read: rd_req<=1, beat_count<=1, addr_out = received address.
- Single-beat completion: if burst_len==0, the same last ADDR edge also sets rx_done<=1, slave_ready<=1 and returns to IDLE.
- Otherwise the next state is WBURST (write) or RBURST (read).
- WBURST:
  - Each next DATA_WIDTH edges shift in one word.
  - On a word's last edge: addr_out<=addr_out+1 (mod 2^ADDR_WIDTH, wraps to 0), data_out updated, wr_valid<=1, beat_count+1.
  - When beat_count reaches burst_len+1: rx_done<=1, slave_ready<=1, go to IDLE.
- RBURST: each edge with master_valid=1 does addr_out+1 (wrapping), rd_req<=1 and beat_count+1. The final beat sets rx_done and returns to IDLE, as in WBURST.
- Abort: master_valid=0 sampled in ADDR, WBURST or RBURST causes:
  - abort<=1, return to IDLE, slave_ready<=1;
  - any partial word is discarded; no wr_valid or rd_req on that edge;
  - addr_out, data_out and beat_count keep their last values.
- Pulses: wr_valid, rd_req, rx_done and abort are high for exactly one cycle and are cleared on every other edge.
- Simultaneous events: abort takes precedence over beat completion on the same edge.
- rx_addr is ignored outside ADDR; rx_data is ignored outside ADDR and WBURST.
- Back-to-back transactions: earliest new handshake is the edge after rx_done or abort.

Test Plan:
1. Single write: AW=12, DW=8, addr 0x2A5, data 0xC3, burst_len=0 -> wr_valid at edge 12 after handshake with addr_out=0x2A5, data_out=0xC3; rx_done same cycle; slave_ready=1 next cycle.
2. Write burst: addr 0x0FE, burst_len=2, words 0x11/0x22/0x33 -> three wr_valid pulses with addresses 0x0FE/0x0FF/0x100 at edges 12, 20, 28; beat_count=3; rx_done at edge 28.
3. Read burst with wrap: addr 0xFFE, burst_len=3 -> rd_req on 4 consecutive edges with addr_out 0xFFE, 0xFFF, 0x000, 0x001; rx_done on the 4th.
4. Abort: write burst_len=4, master_valid dropped during the 3rd word -> abort pulse, no 3rd wr_valid, beat_count=2, slave_ready=1 next cycle, no rx_done.
5. Reset mid-ADDR and handshake qualification: reset asserted at edge 5 -> all outputs 0 immediately; slave_ready=1 after release. Then master_valid=1 with read_en=write_en=0 -> no handshake, state stays IDLE.
6. Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=4, write single with data 0xBEEF -> wr_valid at edge 16, addr_out correct, data_out=0xBEEF.
